mem_port_arbiter: RTL and testbench

Sequencing controller for the single shared memory port. Arbitrates between the MEM-stage data requester and the IF-stage fetch requester, holds the winner for a fixed-latency access, and drives the select line of the mux2_1-cell address/data bank in front of the port. Registered outputs only, so the select is stable for the whole access despite the mux cell gate delays.

---
 rtl/port_arb_pkg.sv | 23 ++
 rtl/mem_port_arbiter_if.sv | 31 +++
 rtl/arb_countdown.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/port_arb_pkg.sv
// Shared types and constants for the shared memory-port arbiter.
// Consumers: mem_port_arbiter, mem_port_arbiter_if, arb_countdown.
package port_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    localparam int REQ_DATA  = 0;
    localparam int REQ_FETCH = 1;

    // One-hot vector for a winner index (0 = data, 1 = fetch).
    function automatic logic [1:0] grant_vec(input logic win);
        if (win) begin
            return 2'b10;
        end else begin
            return 2'b01;
        end
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/grant bundle between the two pipeline requesters and the memory-port arbiter.
// The arbiter uses the slave modport; requesters (or a bench) use the master modport.
interface mem_port_arbiter_if;
    import port_arb_pkg::*;

    logic [1:0] req;
    logic [1:0] gnt;
    logic       sel;
    logic       mem_en;
    logic [1:0] done;
    logic       busy;

    modport master (
        output req,
        input  gnt,
        input  sel,
        input  mem_en,
        input  done,
        input  busy
    );

    modport slave (
        input  req,
        output gnt,
        output sel,
        output mem_en,
        output done,
        output busy
    );

endinterface

// File: rtl/arb_countdown.sv
// Loadable saturating counter with a zero flag; UP=0 counts down, UP=1 counts up.
// Load has priority over step, and the count never wraps in either direction.
module arb_countdown
    import port_arb_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter bit UP    = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_r;

    // Counter register: reset, load, or a saturating step.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (step) begin
            if (UP) begin
                if (cnt_r != {WIDTH{1'b1}}) begin
                    cnt_r <= cnt_r + WIDTH'(1'b1);
                end else begin
                    cnt_r <= cnt_r;
                end
            end else begin
                if (cnt_r != {WIDTH{1'b0}}) begin
                    cnt_r <= cnt_r - WIDTH'(1'b1);
                end else begin
                    cnt_r <= cnt_r;
                end
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign count = cnt_r;
    assign zero  = (cnt_r == {WIDTH{1'b0}});

endmodule

// File: rtl/mem_port_arbiter.sv
// Shared memory-port arbiter: data-over-fetch priority, fixed LAT-cycle access, registered mux select.
// Optional fetch-starvation guard is compiled in with `define ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import port_arb_pkg::*;
#(
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam int             CW       = $clog2(LAT + 1);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(LAT - 1);
    // An out-of-range configuration never grants instead of running a truncated countdown.
    localparam bit CFG_OK = (LAT >= 1) && (LAT <= 15) && (STARVE_MAX >= 1) && (STARVE_MAX <= 15);

    arb_state_e    state_r;
    arb_state_e    state_nxt_s;
    logic [1:0]    gnt_r;
    logic [1:0]    gnt_nxt_s;
    logic [1:0]    done_r;
    logic [1:0]    done_nxt_s;
    logic          sel_r;
    logic          sel_nxt_s;
    logic          mem_en_r;
    logic          mem_en_nxt_s;
    logic          busy_r;
    logic          busy_nxt_s;

    logic          arb_s;
    logic          win_s;
    logic          cnt_step_s;
    logic          cnt_zero_s;
    logic [CW-1:0] cnt_val_s;

    assign arb_s      = CFG_OK && (state_r == IDLE) && (bus.req != 2'b00);
    assign cnt_step_s = (state_r == BUSY) && (cnt_val_s != {CW{1'b0}});

    arb_countdown #(
        .WIDTH (CW),
        .UP    (1'b0)
    ) u_access_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (arb_s),
        .load_val (CNT_LOAD),
        .step     (cnt_step_s),
        .count    (cnt_val_s),
        .zero     (cnt_zero_s)
    );

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_cnt_s;
    logic          starve_zero_s;
    logic          starve_hit_s;
    logic          starve_inc_s;
    logic          starve_clr_s;

    assign starve_hit_s = bus.req[REQ_FETCH] && !starve_zero_s &&
                          (starve_cnt_s == SW'(STARVE_MAX));

    // Winner selection: a saturated starvation count forces fetch through.
    always_comb begin
        win_s = 1'b0;
        if (starve_hit_s) begin
            win_s = 1'b1;
        end else if (bus.req[REQ_DATA]) begin
            win_s = 1'b0;
        end else begin
            win_s = 1'b1;
        end
    end

    assign starve_inc_s = arb_s && !win_s && bus.req[REQ_FETCH];
    assign starve_clr_s = arb_s && (win_s || !bus.req[REQ_FETCH]);

    arb_countdown #(
        .WIDTH (SW),
        .UP    (1'b1)
    ) u_starve_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (starve_clr_s),
        .load_val ({SW{1'b0}}),
        .step     (starve_inc_s),
        .count    (starve_cnt_s),
        .zero     (starve_zero_s)
    );
`else
    // Winner selection: strict data-over-fetch priority.
    always_comb begin
        win_s = 1'b0;
        if (bus.req[REQ_DATA]) begin
            win_s = 1'b0;
        end else begin
            win_s = 1'b1;
        end
    end
`endif

    // State and output registers; outputs only change on a clock edge so sel is glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            gnt_r    <= 2'b00;
            sel_r    <= 1'b0;
            mem_en_r <= 1'b0;
            done_r   <= 2'b00;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            gnt_r    <= gnt_nxt_s;
            sel_r    <= sel_nxt_s;
            mem_en_r <= mem_en_nxt_s;
            done_r   <= done_nxt_s;
            busy_r   <= busy_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (arb_s) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_zero_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Next output values; the winner is remembered in sel_r for the done pulse.
    always_comb begin
        gnt_nxt_s    = gnt_r;
        sel_nxt_s    = sel_r;
        mem_en_nxt_s = mem_en_r;
        done_nxt_s   = 2'b00;
        busy_nxt_s   = busy_r;
        case (state_r)
            IDLE: begin
                if (arb_s) begin
                    gnt_nxt_s    = grant_vec(win_s);
                    sel_nxt_s    = win_s;
                    mem_en_nxt_s = 1'b1;
                    busy_nxt_s   = 1'b1;
                end else begin
                    gnt_nxt_s    = 2'b00;
                    mem_en_nxt_s = 1'b0;
                    busy_nxt_s   = 1'b0;
                end
            end
            BUSY: begin
                if (cnt_zero_s) begin
                    gnt_nxt_s    = 2'b00;
                    mem_en_nxt_s = 1'b0;
                    done_nxt_s   = grant_vec(sel_r);
                    busy_nxt_s   = 1'b1;
                end else begin
                    gnt_nxt_s    = gnt_r;
                    mem_en_nxt_s = 1'b1;
                    busy_nxt_s   = 1'b1;
                end
            end
            DONE: begin
                gnt_nxt_s    = 2'b00;
                mem_en_nxt_s = 1'b0;
                busy_nxt_s   = 1'b0;
            end
            default: begin
                gnt_nxt_s    = 2'b00;
                mem_en_nxt_s = 1'b0;
                busy_nxt_s   = 1'b0;
            end
        endcase
    end

    assign bus.gnt    = gnt_r;
    assign bus.sel    = sel_r;
    assign bus.mem_en = mem_en_r;
    assign bus.done   = done_r;
    assign bus.busy   = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: LAT=2 instance for the main sequence, LAT=1 instance for back-to-back timing.
// Expected done pulses are queued when requests are driven and popped as the arbiter completes accesses.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus_a ();
    mem_port_arbiter_if bus_b ();

    mem_port_arbiter #(.LAT(2), .STARVE_MAX(3)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    mem_port_arbiter #(.LAT(1), .STARVE_MAX(3)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    int         checks = 0;
    int         errors = 0;
    logic [1:0] exp_q[$];
    logic [6:0] va_s;

    assign va_s = {bus_a.gnt, bus_a.sel, bus_a.mem_en, bus_a.done, bus_a.busy};

    function automatic logic [6:0] ex(input logic [1:0] g, input logic s, input logic m,
                                      input logic [1:0] d, input logic b);
        return {g, s, m, d, b};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run ncyc cycles on one instance, popping the queue on every done pulse.
    task automatic run_sb(input bit use_b, input int ncyc, input int spacing,
                          input int first_exp, input int men_exp);
        int         last_i = -1;
        int         first_i = -1;
        int         men = 0;
        int         ovl = 0;
        int         run = 0;
        logic       pm = 1'b0;
        logic [1:0] d;
        logic [1:0] g;
        logic       m;
        for (int i = 1; i <= ncyc; i++) begin
            tick();
            d = use_b ? bus_b.done : bus_a.done;
            g = use_b ? bus_b.gnt : bus_a.gnt;
            m = use_b ? bus_b.mem_en : bus_a.mem_en;
            if (d != 2'b00) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_done", 32'(d), 32'(0));
                end else begin
                    check("sb_done", 32'(d), 32'(exp_q.pop_front()));
                end
                if (last_i < 0) begin
                    first_i = i;
                end else begin
                    check("done_spacing", 32'(i - last_i), 32'(spacing));
                end
                last_i = i;
            end
            if (m) men++;
            if (m && pm) run++;
            pm = m;
            if ((g != 2'b00) && (d != 2'b00)) ovl++;
        end
        check("first_done_cycle", 32'(first_i), 32'(first_exp));
        check("sb_drained", 32'(exp_q.size()), 32'(0));
        check("mem_en_cycles", 32'(men), 32'(men_exp));
        check("gnt_done_overlap", 32'(ovl), 32'(0));
        if (spacing == 3) begin
            check("mem_en_single_cycle", 32'(run), 32'(0));
        end
    endtask

    initial begin
        reset      = 1'b1;
        bus_a.req  = 2'b11;
        bus_b.req  = 2'b00;

        // Reset held with both requests high: everything stays low.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold", 32'(va_s), 32'(ex(2'b00, 1'b0, 1'b0, 2'b00, 1'b0)));
        end

        // Release: data wins the first arbitration.
        reset = 1'b0;
        tick();
        check("first_gnt_data", 32'(va_s), 32'(ex(2'b01, 1'b0, 1'b1, 2'b00, 1'b1)));
        tick();
        check("first_busy_c2", 32'(va_s), 32'(ex(2'b01, 1'b0, 1'b1, 2'b00, 1'b1)));
        tick();
        check("first_done", 32'(va_s), 32'(ex(2'b00, 1'b0, 1'b0, 2'b01, 1'b1)));
        bus_a.req = 2'b00;
        tick();
        check("first_idle", 32'(va_s), 32'(ex(2'b00, 1'b0, 1'b0, 2'b00, 1'b0)));

        // Single fetch request, LAT=2.
        bus_a.req = 2'b10;
        tick();
        check("fetch_c1", 32'(va_s), 32'(ex(2'b10, 1'b1, 1'b1, 2'b00, 1'b1)));
        tick();
        check("fetch_c2", 32'(va_s), 32'(ex(2'b10, 1'b1, 1'b1, 2'b00, 1'b1)));
        tick();
        check("fetch_done", 32'(va_s), 32'(ex(2'b00, 1'b1, 1'b0, 2'b10, 1'b1)));
        bus_a.req = 2'b00;
        tick();
        check("fetch_idle_sel_hold", 32'(va_s), 32'(ex(2'b00, 1'b1, 1'b0, 2'b00, 1'b0)));

        // Both requesting continuously for six accesses.
`ifdef ARB_STARVE_GUARD_EN
        exp_q.push_back(2'b01); exp_q.push_back(2'b01); exp_q.push_back(2'b01);
        exp_q.push_back(2'b10); exp_q.push_back(2'b01); exp_q.push_back(2'b01);
`else
        for (int i = 0; i < 6; i++) exp_q.push_back(2'b01);
`endif
        bus_a.req = 2'b11;
        run_sb(1'b0, 24, 4, 3, 12);
        bus_a.req = 2'b00;

        // Reset during the second BUSY cycle aborts without a done pulse.
        bus_a.req = 2'b01;
        tick();
        check("abort_pre_c1", 32'(va_s), 32'(ex(2'b01, 1'b0, 1'b1, 2'b00, 1'b1)));
        tick();
        reset = 1'b1;
        tick();
        check("abort_reset", 32'(va_s), 32'(ex(2'b00, 1'b0, 1'b0, 2'b00, 1'b0)));
        reset     = 1'b0;
        bus_a.req = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_done", 32'(va_s), 32'(ex(2'b00, 1'b0, 1'b0, 2'b00, 1'b0)));
        end
        bus_a.req = 2'b10;
        tick();
        check("abort_then_idle_gnt", 32'(va_s), 32'(ex(2'b10, 1'b1, 1'b1, 2'b00, 1'b1)));
        tick();
        tick();
        check("abort_then_done", 32'(va_s), 32'(ex(2'b00, 1'b1, 1'b0, 2'b10, 1'b1)));
        bus_a.req = 2'b00;
        tick();

        // LAT=1 instance with back-to-back data requests.
        for (int i = 0; i < 4; i++) exp_q.push_back(2'b01);
        bus_b.req = 2'b01;
        run_sb(1'b1, 12, 3, 2, 4);
        bus_b.req = 2'b00;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
